mod_exp_ctrl: RTL

- Sequencing controller for RSA modular exponentiation: result = m^e mod n.
- Sits directly upstream of the Montgomery multiplier. It drives the multiplier's x/y/reset/enable inputs, consumes its result/finish outputs, and walks the exponent left-to-right (square-and-multiply).
- Handles entry into and exit from the Montgomery domain using a software-supplied R² mod n, where R = 2^(n_len+1).

---
 rtl/mod_exp_ctrl_pkg.sv | 25 ++
 rtl/mod_exp_ctrl_mont_op_seq.sv | 81 ++++++++
 rtl/mod_exp_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mod_exp_ctrl_pkg.sv
// Shared definitions for the RSA modular-exponentiation controller:
// default operand widths, main sequencing states and multiplier handshake phases.
package rsa_pkg;

    localparam int DEF_W  = 2048;
    localparam int DEF_LW = 11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRE_M   = 3'd1,
        PRE_ONE = 3'd2,
        SQR     = 3'd3,
        MUL     = 3'd4,
        POST    = 3'd5,
        FIN     = 3'd6
    } main_state_t;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        SETTLE  = 2'd3
    } op_phase_t;

endpackage

// File: rtl/mod_exp_ctrl_mont_op_seq.sv
// One Montgomery multiplication handshake: latch operands on a request, hold the
// multiplier in reset for one ISSUE cycle, enable it until finish, then give it
// one SETTLE cycle so its final conditional subtract lands before we capture.
module mont_op_seq
    import rsa_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic         o_ack,
    output logic [W-1:0] o_res,
    output logic [W-1:0] mm_x,
    output logic [W-1:0] mm_y,
    output logic         mm_rst,
    output logic         mm_enable,
    input  logic [W+1:0] mm_result,
    input  logic         mm_finish
);

    op_phase_t    r_phase;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic         r_mmRst;
    logic         r_mmEnable;

    // Phase sequencer; operands stay registered so they are stable for the whole WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase    <= OP_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_mmRst    <= 1'b1;
            r_mmEnable <= 1'b0;
        end else begin
            case (r_phase)
                OP_IDLE: begin
                    if (i_req) begin
                        r_x     <= i_x;
                        r_y     <= i_y;
                        r_phase <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mmRst    <= 1'b0;
                    r_mmEnable <= 1'b1;
                    r_phase    <= WAIT;
                end
                WAIT: begin
                    if (mm_finish) begin
                        r_mmEnable <= 1'b0;
                        r_phase    <= SETTLE;
                    end
                end
                SETTLE: begin
                    r_mmRst <= 1'b1;
                    r_phase <= OP_IDLE;
                end
                default: r_phase <= OP_IDLE;
            endcase
        end
    end

    assign mm_x      = r_x;
    assign mm_y      = r_y;
    assign mm_rst    = r_mmRst;
    assign mm_enable = r_mmEnable;
    assign o_ack     = (r_phase == SETTLE);
    assign o_res     = mm_result[W-1:0];

    // A fully reduced multiplier result never carries anything above bit W-1.
    always @(posedge clk) begin
        if (rst && r_phase == SETTLE) begin
            assert (mm_result[W+1:W] == 2'b00);
        end
    end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller computing m^e mod n through an
// external Montgomery multiplier; enters the Montgomery domain with r2 = R^2 mod n
// and leaves it with a final multiply by 1.
module mod_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int LW = DEF_LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  m,
    input  logic [W-1:0]  e,
    input  logic [LW-1:0] e_len,
    input  logic [W-1:0]  n,
    input  logic [LW-1:0] n_len,
    input  logic [W-1:0]  r2,
    output logic [W-1:0]  mm_x,
    output logic [W-1:0]  mm_y,
    output logic          mm_rst,
    output logic          mm_enable,
    input  logic [W+1:0]  mm_result,
    input  logic          mm_finish,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result
);

    main_state_t   r_state;
    logic [W-1:0]  r_m;
    logic [W-1:0]  r_e;
    logic [W-1:0]  r_n;
    logic [W-1:0]  r_r2;
    logic [W-1:0]  r_mbar;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_result;
    logic [LW-1:0] r_bit;
    logic          r_opPend;
    logic          r_busy;
    logic          r_done;

    logic [W-1:0]  w_x;
    logic [W-1:0]  w_y;
    logic [W-1:0]  w_opRes;
    logic          w_isOp;
    logic          w_req;
    logic          w_ack;

    // Operand pair for the multiplication belonging to the current state.
    always_comb begin
        w_x    = '0;
        w_y    = '0;
        w_isOp = 1'b1;
        case (r_state)
            PRE_M:   begin w_x = r_m;       w_y = r_r2;      end
            PRE_ONE: begin w_x = W'(1);     w_y = r_r2;      end
            SQR:     begin w_x = r_acc;     w_y = r_acc;     end
            MUL:     begin w_x = r_acc;     w_y = r_mbar;    end
            POST:    begin w_x = r_acc;     w_y = W'(1);     end
            default: w_isOp = 1'b0;
        endcase
    end

    assign w_req = w_isOp && !r_opPend;

    mont_op_seq #(.W(W)) u_seq (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_req),
        .i_x       (w_x),
        .i_y       (w_y),
        .o_ack     (w_ack),
        .o_res     (w_opRes),
        .mm_x      (mm_x),
        .mm_y      (mm_y),
        .mm_rst    (mm_rst),
        .mm_enable (mm_enable),
        .mm_result (mm_result),
        .mm_finish (mm_finish)
    );

    // Main sequencer: each op state issues one request and advances on its ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_m      <= '0;
            r_e      <= '0;
            r_n      <= '0;
            r_r2     <= '0;
            r_mbar   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_bit    <= '0;
            r_opPend <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_req) r_opPend <= 1'b1;
            if (w_ack) r_opPend <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m      <= m;
                        r_e      <= e;
                        r_n      <= n;
                        r_r2     <= r2;
                        r_bit    <= e_len;
                        r_busy   <= 1'b1;
                        r_opPend <= 1'b0;
                        r_state  <= PRE_M;
                    end
                end
                PRE_M: begin
                    if (w_ack) begin
                        r_mbar  <= w_opRes;
                        r_state <= PRE_ONE;
                    end
                end
                PRE_ONE: begin
                    if (w_ack) begin
                        r_acc   <= w_opRes;
                        r_state <= SQR;
                    end
                end
                SQR: begin
                    if (w_ack) begin
                        r_acc <= w_opRes;
                        if (r_e[r_bit]) begin
                            r_state <= MUL;
                        end else if (r_bit == '0) begin
                            r_state <= POST;
                        end else begin
                            r_bit   <= r_bit - 1'b1;
                            r_state <= SQR;
                        end
                    end
                end
                MUL: begin
                    if (w_ack) begin
                        r_acc <= w_opRes;
                        if (r_bit == '0) begin
                            r_state <= POST;
                        end else begin
                            r_bit   <= r_bit - 1'b1;
                            r_state <= SQR;
                        end
                    end
                end
                POST: begin
                    if (w_ack) begin
                        r_acc    <= w_opRes;
                        r_result <= w_opRes;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= FIN;
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    // Caller contract: odd modulus whose MSB sits at n_len; every product stays below n.
    always @(posedge clk) begin
        if (rst && r_state == IDLE && start) begin
            assert (n[n_len] && n[0]);
        end
        if (rst && w_ack) begin
            assert (w_opRes < r_n);
        end
    end

endmodule
